sys_ctrl_burst: RTL and testbench

- Parametrised next-generation system controller on the REF_CLK domain.
- Decodes the UART command byte stream into register-file accesses and ALU operations, then pushes responses into the TX async FIFO.
- Adds burst read/write commands, a parametrised data/address/ALU width, multi-word ALU result serialisation, FIFO back-pressure stalling and an error flag.

---
 rtl/sys_ctrl_burst.sv | 399 +++++++++++++++++++++++++++++++++++++++
 tb/tb_sys_ctrl_burst.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_burst.sv
// ---------------------------------------------------------------------------
// sys_ctrl_burst
// System controller on the REF_CLK domain. Decodes the UART command byte
// stream into register-file accesses (single and burst) and ALU operations,
// and pushes read data / ALU results into the TX async FIFO.
//
// Optional feature (compile-time macro): CMD_TIMEOUT_EN
//   Defined   : a frame that stalls in a receive state for TIMEOUT_CYCLES
//               cycles is aborted with a CMD_ERR pulse.
//   Undefined : the FSM waits indefinitely for frame bytes.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   RX_DATA/RX_VALID  command byte stream from the UART receiver
//   FIFO_FULL         TX FIFO back-pressure
//   FIFO_WR_DATA/INC  TX FIFO word and one-cycle push
//   ALU_OUT/_VALID    ALU result and its strobe
//   ALU_EN, ALU_FUN   ALU operation strobe and function code
//   CLKG_EN           ALU clock-gate enable
//   CLKDIV_EN         UART clock-divider enable (1 out of reset)
//   RD_DATA/RD_VALID  register-file read return
//   WR_DATA, ADDR     register-file write data and address
//   WR_EN, RD_EN      register-file strobes
//   CMD_ERR           one-cycle pulse on illegal opcode / zero burst count
// ---------------------------------------------------------------------------
module sys_ctrl_burst #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VALID,
  input  logic                  FIFO_FULL,
  output logic [DATA_WIDTH-1:0] FIFO_WR_DATA,
  output logic                  FIFO_WR_INC,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  CLKG_EN,
  output logic                  CLKDIV_EN,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  RD_VALID,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic                  WR_EN,
  output logic                  RD_EN,
  output logic                  CMD_ERR
);

  localparam int ALU_WORDS = (ALU_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int EXT_W     = ALU_WORDS * DATA_WIDTH;
  localparam int WIDX_W    = (ALU_WORDS > 1) ? $clog2(ALU_WORDS) : 1;

  localparam logic [DATA_WIDTH-1:0] OP_SWR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_SRD = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_BWR = DATA_WIDTH'(8'hEE);
  localparam logic [DATA_WIDTH-1:0] OP_BRD = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] OP_ALO = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALN = DATA_WIDTH'(8'hDD);

  typedef enum logic [4:0] {
    IDLE      = 5'd0,
    GET_ADDR  = 5'd1,
    GET_CNT   = 5'd2,
    GET_WDATA = 5'd3,
    DO_WRITE  = 5'd4,
    DO_READ   = 5'd5,
    WAIT_RD   = 5'd6,
    PUSH_RD   = 5'd7,
    GET_OPA   = 5'd8,
    WR_OPA    = 5'd9,
    GET_OPB   = 5'd10,
    WR_OPB    = 5'd11,
    GET_FUN   = 5'd12,
    ALU_GO    = 5'd13,
    ALU_FIRE  = 5'd14,
    ALU_WAIT  = 5'd15,
    PUSH_ALU  = 5'd16
  } state_t;

  typedef enum logic [1:0] {
    MODE_SWR = 2'd0,
    MODE_SRD = 2'd1,
    MODE_BWR = 2'd2,
    MODE_BRD = 2'd3
  } mode_t;

  state_t                state_q, state_d;
  mode_t                 mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [EXT_W-1:0]      alu_res_q, alu_res_d;
  logic [WIDX_W-1:0]     word_q, word_d;
  logic [3:0]            alu_fun_q, alu_fun_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  alu_en_q, alu_en_d;
  logic                  clkg_en_q, clkg_en_d;
  logic                  clkdiv_en_q;
  logic                  in_get;
  logic                  to_abort;
  logic [EXT_W-1:0]      alu_ext;

  // Select one DATA_WIDTH slice of the zero-extended ALU result.
  function automatic logic [DATA_WIDTH-1:0] alu_word(input logic [EXT_W-1:0] res,
                                                     input logic [WIDX_W-1:0] idx);
    logic [EXT_W-1:0] sh;
    sh = res >> (int'(idx) * DATA_WIDTH);
    alu_word = sh[DATA_WIDTH-1:0];
  endfunction

  assign in_get = (state_q == GET_ADDR)  || (state_q == GET_CNT) ||
                  (state_q == GET_WDATA) || (state_q == GET_OPA) ||
                  (state_q == GET_OPB)   || (state_q == GET_FUN);

  // Zero-extend the ALU result to a whole number of FIFO words.
  always_comb begin
    alu_ext                = '0;
    alu_ext[ALU_WIDTH-1:0] = ALU_OUT;
  end

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Idle-cycle counter for a stalled frame: counts only in receive states.
  always_comb begin
    to_cnt_d = '0;
    to_abort = 1'b0;
    if (in_get && !RX_VALID) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        to_abort = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_abort = 1'b0;
`endif

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    fifo_data_d = fifo_data_q;
    alu_res_d   = alu_res_q;
    word_d      = word_q;
    alu_fun_d   = alu_fun_q;
    cmd_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        word_d = '0;
        if (RX_VALID) begin
          case (RX_DATA)
            OP_SWR: begin mode_d = MODE_SWR; state_d = GET_ADDR; end
            OP_SRD: begin mode_d = MODE_SRD; state_d = GET_ADDR; end
            OP_BWR: begin mode_d = MODE_BWR; state_d = GET_ADDR; end
            OP_BRD: begin mode_d = MODE_BRD; state_d = GET_ADDR; end
            OP_ALO: state_d = GET_OPA;
            OP_ALN: state_d = GET_FUN;
            default: cmd_err_d = 1'b1;
          endcase
        end else begin
          state_d = IDLE;
        end
      end

      GET_ADDR: begin
        if (RX_VALID) begin
          addr_d = RX_DATA[ADDR_WIDTH-1:0];
          cnt_d  = DATA_WIDTH'(1);
          case (mode_q)
            MODE_SWR: state_d = GET_WDATA;
            MODE_SRD: state_d = DO_READ;
            default:  state_d = GET_CNT;
          endcase
        end else begin
          state_d = GET_ADDR;
        end
      end

      GET_CNT: begin
        if (RX_VALID) begin
          if (RX_DATA == '0) begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d   = RX_DATA;
            state_d = (mode_q == MODE_BRD) ? DO_READ : GET_WDATA;
          end
        end else begin
          state_d = GET_CNT;
        end
      end

      GET_WDATA: begin
        if (RX_VALID) begin
          wdata_d = RX_DATA;
          state_d = DO_WRITE;
        end else begin
          state_d = GET_WDATA;
        end
      end

      // ADDR is held through the strobe cycle; it advances as the beat retires.
      DO_WRITE: begin
        if (cnt_q == DATA_WIDTH'(1)) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - DATA_WIDTH'(1);
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = GET_WDATA;
        end
      end

      DO_READ: state_d = WAIT_RD;

      WAIT_RD: begin
        if (RD_VALID) begin
          fifo_data_d = RD_DATA;
          state_d     = PUSH_RD;
        end else begin
          state_d = WAIT_RD;
        end
      end

      PUSH_RD: begin
        if (!FIFO_FULL) begin
          if (cnt_q == DATA_WIDTH'(1)) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q - DATA_WIDTH'(1);
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = DO_READ;
          end
        end else begin
          state_d = PUSH_RD;
        end
      end

      GET_OPA: begin
        if (RX_VALID) begin
          wdata_d = RX_DATA;
          addr_d  = ADDR_WIDTH'(0);
          state_d = WR_OPA;
        end else begin
          state_d = GET_OPA;
        end
      end

      WR_OPA: state_d = GET_OPB;

      GET_OPB: begin
        if (RX_VALID) begin
          wdata_d = RX_DATA;
          addr_d  = ADDR_WIDTH'(1);
          state_d = WR_OPB;
        end else begin
          state_d = GET_OPB;
        end
      end

      WR_OPB: state_d = GET_FUN;

      GET_FUN: begin
        if (RX_VALID) begin
          alu_fun_d = RX_DATA[3:0];
          state_d   = ALU_GO;
        end else begin
          state_d = GET_FUN;
        end
      end

      // One cycle with the gate open before the ALU is strobed.
      ALU_GO:   state_d = ALU_FIRE;
      ALU_FIRE: state_d = ALU_WAIT;

      ALU_WAIT: begin
        if (ALU_OUT_VALID) begin
          alu_res_d   = alu_ext;
          fifo_data_d = alu_word(alu_ext, WIDX_W'(0));
          word_d      = '0;
          state_d     = PUSH_ALU;
        end else begin
          state_d = ALU_WAIT;
        end
      end

      PUSH_ALU: begin
        if (!FIFO_FULL) begin
          if (word_q == WIDX_W'(ALU_WORDS - 1)) begin
            word_d  = '0;
            state_d = IDLE;
          end else begin
            word_d      = word_q + WIDX_W'(1);
            fifo_data_d = alu_word(alu_res_q, word_q + WIDX_W'(1));
            state_d     = PUSH_ALU;
          end
        end else begin
          state_d = PUSH_ALU;
        end
      end

      default: state_d = IDLE;
    endcase

    if (to_abort) begin
      state_d   = IDLE;
      cmd_err_d = 1'b1;
    end else begin
      cmd_err_d = cmd_err_d;
    end
  end

  // Strobes are decoded from the next state so they register in step with it.
  always_comb begin
    wr_en_d   = (state_d == DO_WRITE) || (state_d == WR_OPA) || (state_d == WR_OPB);
    rd_en_d   = (state_d == DO_READ);
    alu_en_d  = (state_d == ALU_FIRE);
    clkg_en_d = (state_d == ALU_GO) || (state_d == ALU_FIRE) ||
                (state_d == ALU_WAIT) || (state_d == PUSH_ALU);
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      mode_q      <= MODE_SWR;
      addr_q      <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      fifo_data_q <= '0;
      alu_res_q   <= '0;
      word_q      <= '0;
      alu_fun_q   <= 4'h0;
      cmd_err_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      alu_en_q    <= 1'b0;
      clkg_en_q   <= 1'b0;
      clkdiv_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      fifo_data_q <= fifo_data_d;
      alu_res_q   <= alu_res_d;
      word_q      <= word_d;
      alu_fun_q   <= alu_fun_d;
      cmd_err_q   <= cmd_err_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      alu_en_q    <= alu_en_d;
      clkg_en_q   <= clkg_en_d;
      clkdiv_en_q <= 1'b1;
    end
  end

  // The push is gated by the live FIFO_FULL so a full flag that rises on the
  // push cycle suppresses the write and the word is retried.
  assign FIFO_WR_INC  = ((state_q == PUSH_RD) || (state_q == PUSH_ALU)) && !FIFO_FULL;
  assign FIFO_WR_DATA = fifo_data_q;
  assign ALU_EN       = alu_en_q;
  assign ALU_FUN      = alu_fun_q;
  assign CLKG_EN      = clkg_en_q;
  assign CLKDIV_EN    = clkdiv_en_q;
  assign WR_DATA      = wdata_q;
  assign ADDR         = addr_q;
  assign WR_EN        = wr_en_q;
  assign RD_EN        = rd_en_q;
  assign CMD_ERR      = cmd_err_q;

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// ---------------------------------------------------------------------------
// tb_sys_ctrl_burst
// Directed testbench for sys_ctrl_burst with a behavioural register file
// and ALU. Output activity is logged on the falling clock edge and compared
// against hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_sys_ctrl_burst;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic [7:0]  FIFO_WR_DATA;
  logic        FIFO_WR_INC;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLKG_EN;
  logic        CLKDIV_EN;
  logic [7:0]  RD_DATA;
  logic        RD_VALID;
  logic [7:0]  WR_DATA;
  logic [3:0]  ADDR;
  logic        WR_EN;
  logic        RD_EN;
  logic        CMD_ERR;

  sys_ctrl_burst dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .FIFO_FULL(FIFO_FULL), .FIFO_WR_DATA(FIFO_WR_DATA), .FIFO_WR_INC(FIFO_WR_INC),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID), .ALU_EN(ALU_EN),
    .ALU_FUN(ALU_FUN), .CLKG_EN(CLKG_EN), .CLKDIV_EN(CLKDIV_EN),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .WR_DATA(WR_DATA), .ADDR(ADDR),
    .WR_EN(WR_EN), .RD_EN(RD_EN), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // Behavioural register file (1-cycle read latency) and ALU.
  logic [7:0]  regs [16];
  logic [15:0] alu_val = 16'h0000;
  logic        rd_valid_r = 1'b0;
  logic [7:0]  rd_data_r = 8'h00;
  logic        alu_valid_r = 1'b0;
  logic [15:0] alu_out_r = 16'h0000;

  always @(posedge CLK) begin
    if (WR_EN) regs[ADDR] <= WR_DATA;
    rd_valid_r  <= RD_EN;
    rd_data_r   <= regs[ADDR];
    alu_valid_r <= ALU_EN;
    alu_out_r   <= alu_val;
  end
  assign RD_VALID      = rd_valid_r;
  assign RD_DATA       = rd_data_r;
  assign ALU_OUT_VALID = alu_valid_r;
  assign ALU_OUT       = alu_out_r;

  // Activity log, sampled away from the active edge.
  logic [3:0] wr_addr_log [$];
  logic [7:0] wr_data_log [$];
  logic [7:0] push_log [$];
  int err_cnt = 0, alu_en_cnt = 0, rd_cnt = 0, full_push_cnt = 0;
  logic [3:0] fun_at_en = 4'h0;
  logic       clkg_at_en = 1'b0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (WR_EN) begin
        wr_addr_log.push_back(ADDR);
        wr_data_log.push_back(WR_DATA);
      end
      if (FIFO_WR_INC) push_log.push_back(FIFO_WR_DATA);
      if (FIFO_WR_INC && FIFO_FULL) full_push_cnt++;
      if (CMD_ERR) err_cnt++;
      if (RD_EN) rd_cnt++;
      if (ALU_EN) begin
        alu_en_cnt++;
        fun_at_en  = ALU_FUN;
        clkg_at_en = CLKG_EN;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge CLK);
    #1;
  endtask

  // One-cycle RX strobe followed by a gap so non-receive states retire.
  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
    idle_cycles(3);
  endtask

  task automatic wait_pushes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (push_log.size() < n && k < budget) begin
      @(posedge CLK);
      k++;
    end
    idle_cycles(3);
    check_val(tag, push_log.size(), n);
  endtask

  int wb, pb, eb, ab, rb;

  initial begin
    // Reset values.
    idle_cycles(2);
    @(negedge CLK);
    check_val("rst_strobes", {WR_EN, RD_EN, ALU_EN, CLKG_EN, CLKDIV_EN, CMD_ERR, FIFO_WR_INC}, 7'b0);
    check_val("rst_data", {ADDR, WR_DATA, FIFO_WR_DATA, ALU_FUN}, 24'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle_cycles(2);
    check_val("clkdiv_after_rst", CLKDIV_EN, 1'b1);

    // Single write.
    wb = wr_addr_log.size(); pb = push_log.size();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    check_val("swr_count", wr_addr_log.size() - wb, 1);
    check_val("swr_addr", wr_addr_log[wb], 4'h5);
    check_val("swr_data", wr_data_log[wb], 8'h3C);
    check_val("swr_no_push", push_log.size() - pb, 0);

    // Burst write with address wrap 0xF -> 0x0.
    wb = wr_addr_log.size();
    send_byte(8'hEE); send_byte(8'h0E); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check_val("bwr_count", wr_addr_log.size() - wb, 3);
    check_val("bwr_addr", {wr_addr_log[wb], wr_addr_log[wb+1], wr_addr_log[wb+2]}, 12'hEF0);
    check_val("bwr_data", {wr_data_log[wb], wr_data_log[wb+1], wr_data_log[wb+2]}, 24'h112233);

    // Burst read under FIFO back-pressure.
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h81);
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h0A);
    pb = push_log.size(); rb = rd_cnt;
    FIFO_FULL = 1'b1;
    send_byte(8'hFF); send_byte(8'h02); send_byte(8'h02);
    idle_cycles(10);
    check_val("brd_stall_no_push", push_log.size() - pb, 0);
    check_val("brd_stall_one_read", rd_cnt - rb, 1);
    FIFO_FULL = 1'b0;
    wait_pushes("brd_push_count", pb + 2, 50);
    check_val("brd_data", {push_log[pb], push_log[pb+1]}, 16'h810A);
    check_val("brd_reads", rd_cnt - rb, 2);
    check_val("push_while_full", full_push_cnt, 0);

    // ALU with operands: 7 * 3 = 0x0015, LSW first.
    wb = wr_addr_log.size(); pb = push_log.size(); ab = alu_en_cnt;
    alu_val = 16'h0015;
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h03); send_byte(8'h02);
    wait_pushes("alu_push_count", pb + 2, 50);
    check_val("alu_op_writes", {wr_addr_log[wb], wr_data_log[wb], wr_addr_log[wb+1], wr_data_log[wb+1]}, 24'h007_103);
    check_val("alu_en_count", alu_en_cnt - ab, 1);
    check_val("alu_fun", fun_at_en, 4'h2);
    check_val("alu_gate_at_en", clkg_at_en, 1'b1);
    check_val("alu_words", {push_log[pb], push_log[pb+1]}, 16'h1500);
    check_val("alu_gate_off", CLKG_EN, 1'b0);

    // Illegal opcode and zero burst count.
    wb = wr_addr_log.size(); eb = err_cnt;
    send_byte(8'h55);
    send_byte(8'hEE); send_byte(8'h01); send_byte(8'h00);
    check_val("err_count", err_cnt - eb, 2);
    check_val("err_no_write", wr_addr_log.size() - wb, 0);
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h99);
    check_val("err_then_idle", {wr_addr_log[wb], wr_data_log[wb]}, 12'h499);

    // Asynchronous reset in the middle of a burst.
    send_byte(8'hEE); send_byte(8'h05); send_byte(8'h03); send_byte(8'h11);
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    check_val("midrst_addr_data", {ADDR, WR_DATA}, 12'h000);
    check_val("midrst_clkdiv", CLKDIV_EN, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle_cycles(2);
    wb = wr_addr_log.size();
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h5A);
    check_val("postrst_write", {wr_addr_log.size() - wb, 4'(wr_addr_log[wb]), wr_data_log[wb]}, {32'd1, 4'h7, 8'h5A});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
